// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  // Forward select encodings shared by the D, E and M stage muxes.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // Occupancy of the mult/div unit after a start, in cycles.
  localparam logic [3:0] MD_MULT_LAT = 4'd5;
  localparam logic [3:0] MD_DIV_LAT  = 4'd10;

  // A Tuse of 3 marks an operand the instruction never reads.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Ceiling of the stall cycle counter.
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // A producer stage matches a source only for a real (nonzero) register.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] a3);
    return (src != 5'd0) && (a3 == src);
  endfunction

  // Data hazard: the producer will not have its value ready by the time
  // the consumer in D needs it.
  function automatic logic data_hazard(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] a3,
                                       input logic [1:0] tnew);
    return reg_match(src, a3) && (tuse != TUSE_NONE) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority forward selector: one source register checked against up to
// three producer stages, earliest stage first. A stage only forwards once
// its result is ready (Tnew == 0); otherwise the next stage is tried.
module fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter logic [1:0] CODE0 = FWD_E,
  parameter logic [1:0] CODE1 = FWD_M,
  parameter logic [1:0] CODE2 = FWD_W
) (
  input  logic [4:0] src_i,
  input  logic [2:0] slot_en_i,
  input  logic [4:0] a3_0_i,
  input  logic [1:0] tnew_0_i,
  input  logic [4:0] a3_1_i,
  input  logic [1:0] tnew_1_i,
  input  logic [4:0] a3_2_i,
  input  logic [1:0] tnew_2_i,
  output logic [1:0] sel_o
);

  logic hit0, hit1, hit2;

  // Per-slot readiness: enabled slot, real register match, value ready now.
  always_comb begin
    hit0 = slot_en_i[0] && reg_match(src_i, a3_0_i) && (tnew_0_i == 2'd0);
    hit1 = slot_en_i[1] && reg_match(src_i, a3_1_i) && (tnew_1_i == 2'd0);
    hit2 = slot_en_i[2] && reg_match(src_i, a3_2_i) && (tnew_2_i == 2'd0);
  end

  // Youngest ready producer wins; no ready producer means register file.
  always_comb begin
    sel_o = FWD_RF;
    if (hit0) begin
      sel_o = CODE0;
    end else if (hit1) begin
      sel_o = CODE1;
    end else if (hit2) begin
      sel_o = CODE2;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: stall/bubble generation,
// forward selects for D, E and M, mult/div occupancy and a stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  A3_E,
  input  logic [4:0]  A3_M,
  input  logic [4:0]  A3_W,
  input  logic [1:0]  Tnew_E,
  input  logic [1:0]  Tnew_M,
  input  logic [1:0]  Tnew_W,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  rt_M,
  input  logic        md_use_D,
  input  logic        md_start_E,
  input  logic        md_div_E,
  output logic        stall,
  output logic        clr,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        fwd_rt_M,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        rs_hazard, rt_hazard, md_hazard, stall_now;
  logic [1:0]  fwd_rt_m_sel;

  // Data hazards only come from E and M; anything in W is always forwardable.
  always_comb begin
    rs_hazard = data_hazard(rs_D, tuse_rs_D, A3_E, Tnew_E) ||
                data_hazard(rs_D, tuse_rs_D, A3_M, Tnew_M);
    rt_hazard = data_hazard(rt_D, tuse_rt_D, A3_E, Tnew_E) ||
                data_hazard(rt_D, tuse_rt_D, A3_M, Tnew_M);
  end

  // An md consumer in D waits while the unit runs, including its start cycle.
  always_comb begin
    md_hazard = md_use_D && (md_busy || md_start_E);
    stall_now = rs_hazard || rt_hazard || md_hazard;
  end

  assign stall = stall_now;
  assign clr   = stall_now;

  // D operands may take a value from E, M or W.
  fwd_sel #(.CODE0(FWD_E), .CODE1(FWD_M), .CODE2(FWD_W)) u_fwd_rs_d (
    .src_i(rs_D), .slot_en_i(3'b111),
    .a3_0_i(A3_E), .tnew_0_i(Tnew_E),
    .a3_1_i(A3_M), .tnew_1_i(Tnew_M),
    .a3_2_i(A3_W), .tnew_2_i(Tnew_W),
    .sel_o(fwd_rs_D)
  );

  fwd_sel #(.CODE0(FWD_E), .CODE1(FWD_M), .CODE2(FWD_W)) u_fwd_rt_d (
    .src_i(rt_D), .slot_en_i(3'b111),
    .a3_0_i(A3_E), .tnew_0_i(Tnew_E),
    .a3_1_i(A3_M), .tnew_1_i(Tnew_M),
    .a3_2_i(A3_W), .tnew_2_i(Tnew_W),
    .sel_o(fwd_rt_D)
  );

  // E operands may take a value from M or W; the third slot is unused.
  fwd_sel #(.CODE0(FWD_M), .CODE1(FWD_W), .CODE2(FWD_RF)) u_fwd_rs_e (
    .src_i(rs_E), .slot_en_i(3'b011),
    .a3_0_i(A3_M), .tnew_0_i(Tnew_M),
    .a3_1_i(A3_W), .tnew_1_i(Tnew_W),
    .a3_2_i(5'd0), .tnew_2_i(2'd0),
    .sel_o(fwd_rs_E)
  );

  fwd_sel #(.CODE0(FWD_M), .CODE1(FWD_W), .CODE2(FWD_RF)) u_fwd_rt_e (
    .src_i(rt_E), .slot_en_i(3'b011),
    .a3_0_i(A3_M), .tnew_0_i(Tnew_M),
    .a3_1_i(A3_W), .tnew_1_i(Tnew_W),
    .a3_2_i(5'd0), .tnew_2_i(2'd0),
    .sel_o(fwd_rt_E)
  );

  // The M store-data operand can only be forwarded from W.
  fwd_sel #(.CODE0(FWD_W), .CODE1(FWD_RF), .CODE2(FWD_RF)) u_fwd_rt_m (
    .src_i(rt_M), .slot_en_i(3'b001),
    .a3_0_i(A3_W), .tnew_0_i(Tnew_W),
    .a3_1_i(5'd0), .tnew_1_i(2'd0),
    .a3_2_i(5'd0), .tnew_2_i(2'd0),
    .sel_o(fwd_rt_m_sel)
  );

  assign fwd_rt_M = (fwd_rt_m_sel != FWD_RF);

  // A new start reloads the occupancy counter even mid-operation;
  // otherwise it drains to zero.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_E) begin
      md_cnt_d = md_div_E ? MD_DIV_LAT : MD_MULT_LAT;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  // Count stall cycles, sticking at the ceiling instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_now && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Reset aborts any in-flight mult/div and clears the statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = (md_cnt_q != 4'd0);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with an expected-value queue.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_D, rt_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic [1:0]  Tnew_E, Tnew_M, Tnew_W;
  logic [4:0]  rs_E, rt_E, rt_M;
  logic        md_use_D, md_start_E, md_div_E;
  logic        stall, clr;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic        fwd_rt_M;
  logic        md_busy;
  logic [15:0] stall_cnt;

  typedef enum int {
    S_STALL, S_CLR, S_FRSD, S_FRTD, S_FRSE, S_FRTE, S_FRTM, S_BUSY, S_SCNT
  } sig_e;

  typedef struct {
    sig_e        sig;
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] expCnt = 16'd0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .Tnew_W(Tnew_W),
    .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
    .md_use_D(md_use_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
    .stall(stall), .clr(clr),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .fwd_rt_M(fwd_rt_M), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Free-running pipeline clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] observe(input sig_e s);
    case (s)
      S_STALL: return {15'd0, stall};
      S_CLR:   return {15'd0, clr};
      S_FRSD:  return {14'd0, fwd_rs_D};
      S_FRTD:  return {14'd0, fwd_rt_D};
      S_FRSE:  return {14'd0, fwd_rs_E};
      S_FRTE:  return {14'd0, fwd_rt_E};
      S_FRTM:  return {15'd0, fwd_rt_M};
      S_BUSY:  return {15'd0, md_busy};
      default: return stall_cnt;
    endcase
  endfunction

  task automatic expectVal(input sig_e s, input string tag, input logic [15:0] v);
    exp_t e;
    e.sig = s;
    e.tag = tag;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic expectHaz(input string tag, input logic v);
    expectVal(S_STALL, {tag, "_stall"}, {15'd0, v});
    expectVal(S_CLR,   {tag, "_clr"},   {15'd0, v});
  endtask

  // Drive point: just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Sample point: falling edge, away from the active edge.
  task automatic sampleOutputs();
    @(negedge clk);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Reference stall counter: one step per stalling cycle, saturating.
  task automatic countStall(input logic s);
    if (s && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
  endtask

  task automatic idleInputs();
    rs_D = 0; rt_D = 0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    A3_E = 0; A3_M = 0; A3_W = 0; Tnew_E = 0; Tnew_M = 0; Tnew_W = 0;
    rs_E = 0; rt_E = 0; rt_M = 0;
    md_use_D = 0; md_start_E = 0; md_div_E = 0;
  endtask

  initial begin
    reset = 1'b0;
    idleInputs();

    // Reset state
    #2;
    expectHaz("rst", 1'b0);
    expectVal(S_BUSY, "rst_busy", 16'd0);
    expectVal(S_SCNT, "rst_scnt", 16'd0);
    expectVal(S_FRSD, "rst_frsd", 16'd0);
    checkOutput();

    // Load-use: producer in E, not ready
    applyStimulus();
    reset = 1'b1;
    idleInputs(); rs_D = 5; tuse_rs_D = 0; A3_E = 5; Tnew_E = 2;
    sampleOutputs();
    expectHaz("lu_e", 1'b1);
    expectVal(S_FRSD, "lu_e_frsd", 16'd0);
    expectVal(S_SCNT, "lu_e_scnt", expCnt);
    checkOutput(); countStall(1'b1);

    // Load-use: producer moved to M, still not ready
    applyStimulus();
    idleInputs(); rs_D = 5; tuse_rs_D = 0; A3_M = 5; Tnew_M = 1;
    sampleOutputs();
    expectHaz("lu_m", 1'b1);
    expectVal(S_SCNT, "lu_m_scnt", expCnt);
    checkOutput(); countStall(1'b1);

    // Load-use: producer in W, forward from W everywhere
    applyStimulus();
    idleInputs(); rs_D = 5; tuse_rs_D = 0; A3_W = 5; Tnew_W = 0; rs_E = 5; rt_M = 5;
    sampleOutputs();
    expectHaz("lu_w", 1'b0);
    expectVal(S_FRSD, "lu_w_frsd", 16'd3);
    expectVal(S_FRSE, "lu_w_frse", 16'd3);
    expectVal(S_FRTM, "lu_w_frtm", 16'd1);
    expectVal(S_SCNT, "lu_w_scnt", expCnt);
    checkOutput(); countStall(1'b0);

    // E forwarding prefers M over W
    applyStimulus();
    idleInputs(); A3_M = 7; A3_W = 7; rs_E = 7; rt_E = 7; rt_M = 7;
    sampleOutputs();
    expectHaz("e_pri", 1'b0);
    expectVal(S_FRSE, "e_pri_frse", 16'd2);
    expectVal(S_FRTE, "e_pri_frte", 16'd2);
    expectVal(S_FRTM, "e_pri_frtm", 16'd1);
    checkOutput(); countStall(1'b0);

    // D forwarding priority: all ready -> E
    applyStimulus();
    idleInputs(); rt_D = 8; A3_E = 8; A3_M = 8; A3_W = 8;
    sampleOutputs();
    expectHaz("d_pri", 1'b0);
    expectVal(S_FRTD, "d_pri_frtd", 16'd1);
    checkOutput(); countStall(1'b0);

    // E not ready but Tnew == Tuse -> M forwarded, no stall
    applyStimulus();
    idleInputs(); rt_D = 8; tuse_rt_D = 1; A3_E = 8; Tnew_E = 1; A3_M = 8; A3_W = 8;
    sampleOutputs();
    expectHaz("d_pri2", 1'b0);
    expectVal(S_FRTD, "d_pri2_frtd", 16'd2);
    checkOutput(); countStall(1'b0);

    // Register zero never hazards nor forwards
    applyStimulus();
    idleInputs(); rs_D = 0; tuse_rs_D = 0; A3_E = 0; Tnew_E = 2;
    sampleOutputs();
    expectHaz("zero", 1'b0);
    expectVal(S_FRSD, "zero_frsd", 16'd0);
    checkOutput(); countStall(1'b0);

    // rt hazard from M with Tnew one above Tuse
    applyStimulus();
    idleInputs(); rt_D = 9; tuse_rt_D = 1; A3_M = 9; Tnew_M = 2;
    sampleOutputs();
    expectHaz("rt_m", 1'b1);
    expectVal(S_FRTD, "rt_m_frtd", 16'd0);
    checkOutput(); countStall(1'b1);

    // Divide start with an md consumer waiting in D
    applyStimulus();
    idleInputs(); md_start_E = 1; md_div_E = 1; md_use_D = 1;
    sampleOutputs();
    expectHaz("div_start", 1'b1);
    expectVal(S_BUSY, "div_start_busy", 16'd0);
    expectVal(S_SCNT, "div_start_scnt", expCnt);
    checkOutput(); countStall(1'b1);
    for (int i = 1; i <= 11; i++) begin
      applyStimulus();
      idleInputs(); md_use_D = 1;
      sampleOutputs();
      expectVal(S_BUSY, $sformatf("div_busy_%0d", i), (i <= 10) ? 16'd1 : 16'd0);
      expectVal(S_STALL, $sformatf("div_stall_%0d", i), (i <= 10) ? 16'd1 : 16'd0);
      expectVal(S_SCNT, $sformatf("div_scnt_%0d", i), expCnt);
      checkOutput(); countStall(i <= 10);
    end

    // Multiply start, then reset three cycles later
    applyStimulus();
    idleInputs(); md_start_E = 1;
    sampleOutputs();
    expectVal(S_STALL, "mul_start_stall", 16'd0);
    checkOutput();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      idleInputs();
      sampleOutputs();
      expectVal(S_BUSY, $sformatf("mul_busy_%0d", i), 16'd1);
      checkOutput();
    end
    applyStimulus();
    reset = 1'b0;
    #1;
    expectVal(S_BUSY, "rst_mid_busy", 16'd0);
    expectVal(S_SCNT, "rst_mid_scnt", 16'd0);
    expectHaz("rst_mid", 1'b0);
    checkOutput();
    expCnt = 16'd0;
    applyStimulus();
    reset = 1'b1;
    idleInputs(); md_use_D = 1;
    sampleOutputs();
    expectHaz("post_rst", 1'b0);
    expectVal(S_BUSY, "post_rst_busy", 16'd0);
    expectVal(S_SCNT, "post_rst_scnt", 16'd0);
    checkOutput(); countStall(1'b0);

    // Divide start while a multiply is in flight restarts the latency
    applyStimulus();
    idleInputs(); md_start_E = 1;
    sampleOutputs();
    checkOutput();
    applyStimulus();
    idleInputs(); md_start_E = 1; md_div_E = 1;
    sampleOutputs();
    expectVal(S_BUSY, "restart_busy0", 16'd1);
    checkOutput();
    for (int i = 1; i <= 11; i++) begin
      applyStimulus();
      idleInputs();
      sampleOutputs();
      expectVal(S_BUSY, $sformatf("restart_busy_%0d", i), (i <= 10) ? 16'd1 : 16'd0);
      checkOutput();
    end
    expectVal(S_SCNT, "restart_scnt", expCnt);
    checkOutput();

    // Saturation of the stall counter
    applyStimulus();
    idleInputs(); rs_D = 5; tuse_rs_D = 0; A3_E = 5; Tnew_E = 2;
    for (int i = 0; i < 70000; i++) begin
      sampleOutputs();
      if (i == 0 || i == 65534 || i == 65535 || i == 69999) begin
        expectVal(S_STALL, $sformatf("sat_stall_%0d", i), 16'd1);
        expectVal(S_SCNT, $sformatf("sat_scnt_%0d", i), expCnt);
        checkOutput();
      end
      countStall(1'b1);
      applyStimulus();
    end
    idleInputs();
    sampleOutputs();
    expectHaz("sat_end", 1'b0);
    expectVal(S_SCNT, "sat_end_scnt", 16'hFFFF);
    checkOutput();
    applyStimulus();
    sampleOutputs();
    expectVal(S_SCNT, "sat_hold_scnt", 16'hFFFF);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: the clock is named clk, the reset is named reset, and reset asserts when low.
REQ-002 SHALL have these ports, in this order (name, direction, width, meaning):
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  async active-low reset.
- rs_D, rt_D  in  5 each  source registers of the instruction in D.
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until D needs rs/rt; 3 means unused.
- A3_E, A3_M, A3_W  in  5 each  destination register per stage; 0 means no write.
- Tnew_E, Tnew_M, Tnew_W  in  2 each  cycles until that stage's result is ready.
- rs_E, rt_E, rt_M  in  5 each  source registers read in E and M.
- md_use_D  in  1  D instruction reads HI/LO or starts mult/div.
- md_start_E  in  1  mult/div start in E, single-cycle pulse.
- md_div_E  in  1  1 = divide, 0 = multiply; qualifies md_start_E.
- stall  out  1  hold PC and the F/D register.
- clr  out  1  bubble the D/E register.
- fwd_rs_D, fwd_rt_D  out  2 each  D forward select: 0 RF, 1 E, 2 M, 3 W.
- fwd_rs_E, fwd_rt_E  out  2 each  E forward select: 0 none, 2 M, 3 W.
- fwd_rt_M  out  1  M forward select: 0 none, 1 W.
- md_busy  out  1  mult/div unit occupied.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-003 SHALL treat a stage X as a match for source s when s != 0 and A3_X == s.
REQ-004 SHALL raise a rs data hazard when rs_D matches E with Tnew_E > tuse_rs_D, or matches M with Tnew_M > tuse_rs_D; rt uses rt_D and tuse_rt_D the same way.
REQ-005 SHALL raise an md hazard when md_use_D = 1 and (md_busy = 1 or md_start_E = 1).
REQ-006 SHALL set stall = clr = OR of the rs, rt and md hazards; both outputs are combinational, with zero-cycle latency from the inputs.
REQ-007 SHALL pick each D forward select from the first matching stage whose Tnew is 0, in priority E, then M, then W; if none match, the select is 0.
REQ-008 SHALL pick each E forward select in priority M, then W, under the same rule; fwd_rt_M = 1 when rt_M matches W and Tnew_W == 0.
REQ-009 SHALL never forward for register 0, even when A3 == 0 matches a source of 0.
REQ-010 SHALL compute forward selects independently of stall; they are valid every cycle.
REQ-011 SHALL hold a 4-bit md_cnt register:
- md_start_E loads 10 for divide and 5 for multiply, taking priority over the decrement.
- otherwise md_cnt decrements while nonzero and holds at 0.
REQ-012 SHALL drive md_busy = (md_cnt != 0), registered; the cycle of md_start_E is covered by REQ-005, not by md_busy.
REQ-013 SHALL restart md_cnt with the new latency when md_start_E arrives while md_busy = 1.
REQ-014 SHALL increment stall_cnt on each rising edge where stall = 1, saturating at 16'hFFFF without wrapping.

Reset
REQ-015 SHALL, while reset = 0 and independent of clk, force md_cnt = 0, md_busy = 0 and stall_cnt = 0.
REQ-016 SHALL keep stall and clr purely combinational during reset, so they follow the inputs (normally all-zero pipeline registers, giving 0).
REQ-017 SHALL abort any mult/div in flight when reset asserts; no residual busy remains after release.
REQ-018 SHALL resume counting on the first rising edge after reset returns high.

Structure
REQ-019 SHALL take these constants from the shared package:
- FWD_RF = 0, FWD_E = 1, FWD_M = 2, FWD_W = 3.
- MD_MULT_LAT = 5, MD_DIV_LAT = 10.
- TUSE_NONE = 3.
REQ-020 SHALL contain one sub-module, fwd_sel, instantiated once per forwarded operand (5 instances): it is the priority match of one source register against up to three stage (A3, Tnew) pairs.
REQ-021 SHALL keep the target size at 120-400 lines of RTL, with no other state beyond md_cnt and stall_cnt.

Verification
REQ-022 Load-use: rs_D=5, tuse_rs_D=0, A3_E=5, Tnew_E=2 -> stall=1, clr=1 that cycle; next cycle with A3_M=5, Tnew_M=1 -> stall=1; then A3_W=5, Tnew_W=0 -> stall=0, fwd_rs_D=3.
REQ-023 Priority: rt_D=8 matching A3_E, A3_M and A3_W, all with Tnew=0 -> fwd_rt_D=1; with Tnew_E=1 and tuse_rt_D=1 -> fwd_rt_D=2 and stall=0.
REQ-024 Zero register: rs_D=0, A3_E=0, Tnew_E=2, tuse_rs_D=0 -> stall=0, fwd_rs_D=0.
REQ-025 Divide: md_start_E=1, md_div_E=1 -> md_busy=1 for exactly 10 cycles; md_use_D=1 throughout -> stall=1 on 11 consecutive cycles, stall_cnt advances by 11.
REQ-026 Reset mid-op: reset pulled low 3 cycles after a multiply start -> md_busy=0 and stall_cnt=0 immediately, before any clk edge; after release, md_use_D=1 -> stall=0.
REQ-027 Saturation: hold stall=1 for 70000 cycles -> stall_cnt=16'hFFFF and stays there.
